sample_iter: RTL
================

# sample_iter

Rasterizer stage directly downstream of the bounding-box stage and upstream of the sample-hash/sample-test stages. Accepts one triangle per handshake: three vertices, a color, a sample-aligned bounding box and the subsample rate. Walks every sample position inside the box in raster order, left to right then bottom to top, and emits one sample per accepted output beat. The triangle, color and rate are forwarded with each sample. Valid/ready backpressure is supported on both sides.

## Interface
- SIGFIG, default rast_params::SIGFIG (24): bits per coordinate/color component.
- RADIX, default rast_params::RADIX (10): fraction bits; one pixel = 1<<RADIX.
- VERTS, default rast_params::VERTS (3); AXIS, default rast_params::AXIS (3); COLORS, default rast_params::COLORS (3).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  triangle + box presented.
- in_ready  out  1  block will accept the triangle this cycle.
- in_tri  in  VERTS*AXIS*SIGFIG  signed vertex coordinates.
- in_color  in  COLORS*SIGFIG  triangle color.
- in_box  in  2*2*SIGFIG  {ur_y, ur_x, ll_y, ll_x}, signed, sample-grid aligned.
- in_subsamp  in  4  one-hot rate: 4'b1000 = 1/px, 4'b0100 = 4/px, 4'b0010 = 16/px, 4'b0001 = 64/px.
- out_valid  out  1  sample presented.
- out_ready  in  1  downstream accepts sample.
- out_tri, out_color, out_subsamp  out  same widths  latched triangle data.
- out_sample  out  2*SIGFIG  {y, x} current sample position.
- out_last  out  1  current sample is the final one of the triangle.

## Operation
- FSM with two states, WAIT and TEST. Reset state is WAIT.
- **Step size:** step = 1<<RADIX, 1<<(RADIX-1), 1<<(RADIX-2) or 1<<(RADIX-3) for rates 1, 4, 16 and 64 respectively. The step is latched at accept. A non-one-hot in_subsamp is illegal, and its behaviour is undefined.
- **WAIT:** in_ready = 1 and out_valid = 0. When in_valid is 1:
  - Latch tri, color, box and rate, and set sample = (ll_x, ll_y).
  - If ur_x < ll_x or ur_y < ll_y (signed compare), the triangle is consumed and dropped. Stay in WAIT.
  - Otherwise go to TEST.
- **TEST:** out_valid = 1. out_last = (x == ur_x && y == ur_y). On out_valid && out_ready:
  - Not at row end (x != ur_x): x += step.
  - At row end but not the last sample: x = ll_x, y += step.
  - On the last sample: go to WAIT, unless a new triangle is accepted in the same cycle.
- **Back-to-back:** in_ready = WAIT || (TEST && out_last && out_ready). A triangle accepted in that last cycle loads directly and stays in TEST, with no bubble. A degenerate box accepted in that cycle goes to WAIT.
- **Arithmetic:** SIGFIG-bit signed adds. Box coordinates are multiples of step (bbox guarantees this; it is not checked). Overflow is impossible within the screen range.
- Outputs are held stable while out_valid && !out_ready.
- Input data is ignored whenever in_ready = 0.

## Timing
- Triangle accepted at edge N: first sample is valid after edge N; out_valid is registered.
- With no stalls, throughput is 1 sample/cycle. A box of W x H samples occupies exactly W*H cycles in TEST.
- in_ready is combinational from state, out_last and out_ready. It has no combinational path from in_valid.
- **Reset:** any assertion of rst_n = 0 forces WAIT asynchronously and discards the in-flight triangle. All outputs read 0 during and after reset: out_valid, out_last, out_sample, out_tri, out_color, out_subsamp, and the perf counter. in_ready is 1 after reset.

## Configuration
- **ITER_PERF_EN defined:** adds output perf_samp_cnt (32 bits).
  - Increments on every out_valid && out_ready.
  - Wraps at 2^32 - 1 to 0.
  - Cleared only by reset.
- **ITER_PERF_EN undefined:** no port, no counter. Logic is otherwise identical.

## Structure
- Add to rast_params:
  - typedef sample_t as a {y, x} pair of signed SIGFIG-bit values;
  - typedef box_t as {ur, ll} sample_t;
  - an enum iter_state_t with WAIT and TEST;
  - a function subsamp_step(rate) returning the step.
- One sub-module, sample_iter_step: combinational next-sample, row-end and last-sample logic. The FSM and registers stay in sample_iter.

## Test plan
- Box ll = (0,0), ur = (1024,1024), rate 1/px, out_ready = 1 -> 4 samples, in order:
  - (0,0), (1024,0), (0,1024), (1024,1024);
  - out_last on the 4th only; in_ready = 1 on the 4th cycle.
- Same box at 4/px (step 512) -> 9 samples; the row wraps back to x = 0 after x = 1024.
- Rate 1/px, 2x1 box, out_ready low for 3 cycles on the first sample -> out_sample and out_tri are held at (0,0); then (1024,0) follows.
- Two 1-sample triangles presented back-to-back -> accepted on consecutive cycles, out_valid continuous, no bubble.
- Degenerate box ll = (2048,0), ur = (1024,0) -> accepted, zero samples emitted, block back in WAIT the next cycle.
- Reset asserted mid-triangle (after sample 2 of 9) -> out_valid = 0 immediately. After release, a new triangle starts at its own ll. With ITER_PERF_EN, perf_samp_cnt reads 0.

Source files
------------

// File: rtl/sample_iter_pkg.sv
// sample_iter_pkg: rasterizer parameters, sample/box types, iterator state and subsample step helper
package sample_iter_pkg;
  localparam int SIGFIG = 24;
  localparam int RADIX = 10;
  localparam int VERTS = 3;
  localparam int AXIS = 3;
  localparam int COLORS = 3;
  typedef struct packed {
    logic signed [SIGFIG-1:0] y;
    logic signed [SIGFIG-1:0] x;
  } sample_t;
  typedef struct packed {
    sample_t ur;
    sample_t ll;
  } box_t;
  typedef enum logic {WAIT, TEST} iter_state_t;
  // one-hot rate 1/4/16/64 per pixel maps to a pixel, half, quarter or eighth pixel step
  function automatic logic [31:0] subsamp_step(input logic [3:0] rate, input int radix = RADIX);
    return 32'd1 << (rate == 4'b1000 ? radix : rate == 4'b0100 ? radix - 1 : rate == 4'b0010 ? radix - 2 : radix - 3);
  endfunction
endpackage

// File: rtl/sample_iter_step.sv
// sample_iter_step: next raster position, row-end and last-sample detection for the box walk
module sample_iter_step #(
  parameter int SIGFIG = 24
) (
  input  logic signed [SIGFIG-1:0] i_x,
  input  logic signed [SIGFIG-1:0] i_y,
  input  logic signed [SIGFIG-1:0] i_ll_x,
  input  logic signed [SIGFIG-1:0] i_ur_x,
  input  logic signed [SIGFIG-1:0] i_ur_y,
  input  logic signed [SIGFIG-1:0] i_step,
  output logic signed [SIGFIG-1:0] o_nx,
  output logic signed [SIGFIG-1:0] o_ny,
  output logic                     o_last
);
  logic w_row_end;
  assign w_row_end = i_x == i_ur_x;
  assign o_last = w_row_end && i_y == i_ur_y;
  assign o_nx = w_row_end ? i_ll_x : i_x + i_step;
  assign o_ny = w_row_end ? i_y + i_step : i_y;
endmodule

// File: rtl/sample_iter.sv
// sample_iter: walks every sample of a triangle's bounding box in raster order; ITER_PERF_EN adds perf_samp_cnt
module sample_iter #(
  parameter int SIGFIG = sample_iter_pkg::SIGFIG,
  parameter int RADIX = sample_iter_pkg::RADIX,
  parameter int VERTS = sample_iter_pkg::VERTS,
  parameter int AXIS = sample_iter_pkg::AXIS,
  parameter int COLORS = sample_iter_pkg::COLORS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [VERTS*AXIS*SIGFIG-1:0]  in_tri,
  input  logic [COLORS*SIGFIG-1:0]      in_color,
  input  logic [4*SIGFIG-1:0]           in_box,
  input  logic [3:0]                    in_subsamp,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [VERTS*AXIS*SIGFIG-1:0]  out_tri,
  output logic [COLORS*SIGFIG-1:0]      out_color,
  output logic [3:0]                    out_subsamp,
  output logic [2*SIGFIG-1:0]           out_sample,
  output logic                          out_last
`ifdef ITER_PERF_EN
  ,
  output logic [31:0]                   perf_samp_cnt
`endif
);
  import sample_iter_pkg::*;
  iter_state_t r_state;
  logic [VERTS*AXIS*SIGFIG-1:0] r_tri;
  logic [COLORS*SIGFIG-1:0] r_color;
  logic [3:0] r_sub;
  logic signed [SIGFIG-1:0] r_x, r_y, r_llx, r_urx, r_ury, r_step;
  logic signed [SIGFIG-1:0] w_llx, w_lly, w_urx, w_ury, w_nx, w_ny;
  logic w_last, w_test, w_acc, w_degen;
  assign w_llx = in_box[SIGFIG-1:0];
  assign w_lly = in_box[2*SIGFIG-1:SIGFIG];
  assign w_urx = in_box[3*SIGFIG-1:2*SIGFIG];
  assign w_ury = in_box[4*SIGFIG-1:3*SIGFIG];
  assign w_degen = w_urx < w_llx || w_ury < w_lly;
  assign w_test = r_state == TEST;
  assign in_ready = !w_test || (w_last && out_ready);
  assign w_acc = in_valid && in_ready;
  assign out_valid = w_test;
  assign out_last = w_test && w_last;
  assign out_sample = {r_y, r_x};
  assign out_tri = r_tri;
  assign out_color = r_color;
  assign out_subsamp = r_sub;
  sample_iter_step #(.SIGFIG(SIGFIG)) u_step (
    .i_x(r_x), .i_y(r_y), .i_ll_x(r_llx), .i_ur_x(r_urx), .i_ur_y(r_ury), .i_step(r_step),
    .o_nx(w_nx), .o_ny(w_ny), .o_last(w_last)
  );
  // accept loads a new box (also on the final beat of the previous one); each output beat advances the walk
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= WAIT;
      r_tri <= '0;
      r_color <= '0;
      r_sub <= '0;
      r_x <= '0;
      r_y <= '0;
      r_llx <= '0;
      r_urx <= '0;
      r_ury <= '0;
      r_step <= '0;
    end else if (w_acc) begin
      r_state <= w_degen ? WAIT : TEST;
      r_tri <= in_tri;
      r_color <= in_color;
      r_sub <= in_subsamp;
      r_x <= w_llx;
      r_y <= w_lly;
      r_llx <= w_llx;
      r_urx <= w_urx;
      r_ury <= w_ury;
      r_step <= SIGFIG'(subsamp_step(in_subsamp, RADIX));
    end else if (w_test && out_ready) begin
      if (w_last) r_state <= WAIT;
      else begin
        r_x <= w_nx;
        r_y <= w_ny;
      end
    end
`ifdef ITER_PERF_EN
  logic [31:0] r_cnt;
  // count every accepted output sample, wrapping naturally
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (w_test && out_ready) r_cnt <= r_cnt + 32'd1;
  assign perf_samp_cnt = r_cnt;
`endif
endmodule
